// File: rtl/target_generator_pkg.sv
// Shared constants for the snake target generator: master-state codes, grid size,
// FSM encodings and LFSR setup. SnakeControl imports the same package.
package target_generator_pkg;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_PLAY = 2'd1;
  localparam logic [1:0] MS_OVER = 2'd2;

  localparam logic [7:0] H_CELLS = 8'd160;
  localparam logic [6:0] V_CELLS = 7'd120;
  localparam logic [7:0] H_INIT  = 8'd80;
  localparam logic [6:0] V_INIT  = 7'd60;

  localparam logic [7:0] H_SEED  = 8'hA5;
  localparam logic [6:0] V_SEED  = 7'h2B;

  // Feedback masks realise s[n+W] = XOR of the polynomial's lower terms, oldest bit in the MSB.
  localparam logic [7:0] H_TAPS  = 8'h8E;  // x^8+x^6+x^5+x^4+1
  localparam logic [6:0] V_TAPS  = 7'h41;  // x^7+x^6+1

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE    = 2'd0;
  localparam fsm_state_t ST_PICK    = 2'd1;
  localparam fsm_state_t ST_WAIT_LO = 2'd2;
  localparam fsm_state_t ST_ARMED   = 2'd3;

  // LFSR values never reach twice the grid size, so one conditional subtract folds them in range.
  function automatic logic [7:0] reduce_h(input logic [7:0] x);
    return (x >= H_CELLS) ? x - H_CELLS : x;
  endfunction

  function automatic logic [6:0] reduce_v(input logic [6:0] x);
    return (x >= V_CELLS) ? x - V_CELLS : x;
  endfunction

endpackage

// File: rtl/target_generator_lfsr.sv
// Free-running Fibonacci LFSR: shifts left every cycle, feedback is the parity of the tapped bits.
module target_generator_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= SEED;
    else          q <= {q[WIDTH-2:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/target_generator.sv
// Snake target generator: places pseudo-random targets on the grid and counts captures.
// Define TARGET_SCORE_EN to build the score counter; otherwise score is tied to zero.
module target_generator
  import target_generator_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] m_state,
  input  logic       reached,
  output logic [7:0] target_h,
  output logic [6:0] target_v,
  output logic       new_target,
  output logic [7:0] score,
  output logic [1:0] dbg_state
);

  logic [7:0] lfsr_h;
  logic [6:0] lfsr_v;
  fsm_state_t state, state_nxt;
  logic       playing;
  logic       capture;
  logic       game_start;

  target_generator_lfsr #(.WIDTH(8), .TAPS(H_TAPS), .SEED(H_SEED)) u_lfsr_h (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_h)
  );

  target_generator_lfsr #(.WIDTH(7), .TAPS(V_TAPS), .SEED(V_SEED)) u_lfsr_v (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_v)
  );

  assign playing    = (m_state == MS_PLAY);
  assign capture    = playing && (state == ST_ARMED) && reached;
  assign game_start = playing && (state == ST_IDLE);
  assign dbg_state  = state;

  // Leaving play from any state returns to IDLE; REACHED only counts once re-armed by a low.
  always_comb begin
    state_nxt = state;
    if (!playing) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_PICK;
        ST_PICK:    state_nxt = ST_WAIT_LO;
        ST_WAIT_LO: if (!reached) state_nxt = ST_ARMED;
        ST_ARMED:   if (capture) state_nxt = ST_PICK;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      target_h   <= H_INIT;
      target_v   <= V_INIT;
      new_target <= 1'b0;
    end else begin
      state      <= state_nxt;
      new_target <= playing && (state == ST_PICK);
      if (!playing) begin
        target_h <= H_INIT;
        target_v <= V_INIT;
      end else if (state == ST_PICK) begin
        target_h <= reduce_h(lfsr_h);
        target_v <= reduce_v(lfsr_v);
      end
    end
  end

`ifdef TARGET_SCORE_EN
  logic [7:0] score_q;

  // Cleared on game start, held through game-over, saturates at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          score_q <= 8'd0;
    else if (game_start)                   score_q <= 8'd0;
    else if (capture && score_q != 8'hFF)  score_q <= score_q + 8'd1;
  end

  assign score = score_q;
`else
  logic unused_start;
  assign unused_start = game_start;
  assign score        = 8'd0;
`endif

endmodule

// File: tb/tb_target_generator.sv
// Randomised bench for target_generator against a bit-stream / capture-count reference model.
module tb_target_generator;

`ifdef TARGET_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif
  localparam logic [7:0] SEED_H = 8'hA5;
  localparam logic [6:0] SEED_V = 7'h2B;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] m_state = 2'd0;
  logic       reached = 1'b0;
  logic [7:0] target_h;
  logic [6:0] target_v;
  logic       new_target;
  logic [7:0] score;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  target_generator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m_state    (m_state),
    .reached    (reached),
    .target_h   (target_h),
    .target_v   (target_v),
    .new_target (new_target),
    .score      (score),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: LFSRs as bit streams (index 0 = oldest), game as capture rules
  bit hq[$];
  bit vq[$];
  int exp_h, exp_v, exp_score, captures;
  bit exp_pulse;
  bit playing, pick_due, wait_low;

  function automatic int lfsr_h_val();
    int v = 0;
    foreach (hq[i]) v = v * 2 + int'(hq[i]);
    return v;
  endfunction

  function automatic int lfsr_v_val();
    int v = 0;
    foreach (vq[i]) v = v * 2 + int'(vq[i]);
    return v;
  endfunction

  function automatic bit model_armed();
    return playing && !pick_due && !wait_low;
  endfunction

  task automatic model_reset();
    hq.delete();
    vq.delete();
    for (int i = 7; i >= 0; i--) hq.push_back(SEED_H[i]);
    for (int i = 6; i >= 0; i--) vq.push_back(SEED_V[i]);
    exp_h = 80; exp_v = 60; exp_score = 0; exp_pulse = 0;
    playing = 0; pick_due = 0; wait_low = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      exp_pulse = 0;
      if (m_state != 2'd1) begin
        playing = 0; pick_due = 0; wait_low = 0;
        exp_h = 80; exp_v = 60;
      end else if (!playing) begin
        playing = 1; pick_due = 1; exp_score = 0;
      end else if (pick_due) begin
        exp_h = lfsr_h_val() % 160;
        exp_v = lfsr_v_val() % 120;
        exp_pulse = 1; pick_due = 0; wait_low = 1;
      end else if (wait_low) begin
        if (!reached) wait_low = 0;
      end else if (reached) begin
        captures++;
        if (SCORE_EN && exp_score < 255) exp_score++;
        pick_due = 1;
      end
      // s[n+8] = s[n+6]^s[n+5]^s[n+4]^s[n];  s[n+7] = s[n+6]^s[n]
      hq.push_back(hq[6] ^ hq[5] ^ hq[4] ^ hq[0]);
      void'(hq.pop_front());
      vq.push_back(vq[6] ^ vq[0]);
      void'(vq.pop_front());
    end
  end

  // driver: advance one cycle and compare all outputs at the falling edge
  task automatic cycle();
    @(negedge clk);
    check("target_h", 32'(target_h), 32'(exp_h));
    check("target_v", 32'(target_v), 32'(exp_v));
    check("new_target", 32'(new_target), 32'(exp_pulse));
    check("score", 32'(score), 32'(exp_score));
    check("h_range", (target_h < 8'd160) ? 32'd1 : 32'd0, 32'd1);
    check("v_range", (target_v < 7'd120) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_armed(input string tag);
    int k = 0;
    while (!model_armed() && k < 50) begin
      cycle();
      k++;
    end
    check(tag, model_armed() ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, score0, held;
    captures = 0;
    model_reset();

    // reset state
    #12;
    check("rst_h", 32'(target_h), 32'd80);
    check("rst_v", 32'(target_v), 32'd60);
    check("rst_pulse", 32'(new_target), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    #11 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // game start: one pick, one pulse
    m_state = 2'd1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (new_target) pulses++;
    end
    check("t2_pulse_count", 32'(pulses), 32'd1);

    // long REACHED in ARMED: one capture, one new target
    wait_armed("t3_armed");
    score0 = int'(score);
    pulses = 0;
    reached = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (new_target) pulses++;
    end
    reached = 1'b0;
    check("t3_pulse_count", 32'(pulses), 32'd1);
    check("t3_score_delta", 32'(int'(score) - score0), SCORE_EN ? 32'd1 : 32'd0);

    // game over while in WAIT_LO
    wait_armed("t5_armed");
    reached = 1'b1;
    cycle();
    cycle();
    check("t5_in_wait_lo", wait_low ? 32'd1 : 32'd0, 32'd1);
    held = exp_score;
    m_state = 2'd2;
    cycle();
    reached = 1'b0;
    cycle();
    check("t5_over_h", 32'(target_h), 32'd80);
    check("t5_over_v", 32'(target_v), 32'd60);
    check("t5_score_held", 32'(score), 32'(held));
    m_state = 2'd1;
    cycle();
    check("t5_score_clear", 32'(score), 32'd0);

    // random REACHED pulses until saturation
    for (int p = 0; p < 600; p++) begin
      int gap = $urandom_range(6, 1);
      int len = $urandom_range(4, 1);
      reached = 1'b0;
      for (int i = 0; i < gap; i++) cycle();
      reached = 1'b1;
      for (int i = 0; i < len; i++) cycle();
    end
    reached = 1'b0;
    cycle();
    check("t4_score_sat", 32'(score), SCORE_EN ? 32'd255 : 32'd0);

    // asynchronous reset mid-play
    for (int i = 0; i < 5; i++) begin
      reached = 1'($urandom_range(1, 0));
      cycle();
    end
    #2 reset_n = 1'b0;
    #1;
    check("t1_async_h", 32'(target_h), 32'd80);
    check("t1_async_v", 32'(target_v), 32'd60);
    check("t1_async_pulse", 32'(new_target), 32'd0);
    check("t1_async_score", 32'(score), 32'd0);
    reached = 1'b0;
    cycle();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
